// File: rtl/jk_pkg.sv
// Shared types and constants for the JK sequence driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jk_pkg;

    // Driver sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // JK excitation codes, packed as {J, K}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_seq_driver_if.sv
// Pattern handshake plus JK flip-flop drive/observe signals of the sequence driver.
// Latency: n/a (wires only).
// Backpressure: pat_ready is high only while the driver is idle.
interface jk_seq_driver_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             pat_valid;
    logic [WIDTH-1:0] pat_data;
    logic             pat_ready;
    logic             q_in;
    logic             j_o;
    logic             k_o;
    logic             mismatch_o;
    logic             done_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             pass_o;

    // Pattern source / flip-flop side
    modport master (
        output pat_valid, pat_data, q_in,
        input  pat_ready, j_o, k_o, mismatch_o, done_o, err_cnt_o, pass_o
    );

    // Driver side
    modport slave (
        input  pat_valid, pat_data, q_in,
        output pat_ready, j_o, k_o, mismatch_o, done_o, err_cnt_o, pass_o
    );

endinterface

// File: rtl/jk_excite.sv
// JK excitation: J/K needed to move a JK flip-flop from q to target in one edge.
// Latency: combinational.
// Backpressure: none.
module jk_excite
    import jk_pkg::*;
(
    input  logic q,
    input  logic target,
    input  logic use_toggle,
    output logic j,
    output logic k
);

    logic [1:0] w_code;

    // Hold when already at target, otherwise toggle or set/reset toward it
    always_comb begin
        w_code = JK_HOLD;
        if (q != target) begin
            if (use_toggle) begin
                w_code = JK_TOGGLE;
            end else if (target) begin
                w_code = JK_SET;
            end else begin
                w_code = JK_RESET;
            end
        end
    end

    assign j = w_code[1];
    assign k = w_code[0];

endmodule

// File: rtl/jk_seq_driver.sv
// Drives an external JK flip-flop through a WIDTH-bit target sequence (LSB first) and checks each bit.
// Latency: 2 cycles per bit; done_o in cycle 2*WIDTH+1 after acceptance.
// Backpressure: pat_ready only in IDLE; pat_valid at any other time is ignored, nothing is queued.
module jk_seq_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit USE_TOGGLE = 1'b0
)(
    input  logic            clk,
    input  logic            rst_n,
    jk_seq_driver_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pat;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_err;
    logic             r_j;
    logic             r_k;
    logic             r_mis;

    logic             w_accept;
    logic             w_load_jk;
    logic             w_last;
    logic             w_bit_mis;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_ex_tgt;
    logic             w_ex_j;
    logic             w_ex_k;

    assign w_last    = (r_idx == IDX_W'(WIDTH - 1));
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_bit_mis = (bus.q_in != r_pat[r_idx]);

    // First bit comes straight off the bus at acceptance; later bits from the latched pattern
    assign w_ex_tgt = (r_state == IDLE) ? bus.pat_data[0]
                    : (w_last ? 1'b0 : r_pat[w_idx_nxt]);

    jk_excite u_excite (
        .q          (bus.q_in),
        .target     (w_ex_tgt),
        .use_toggle (USE_TOGGLE),
        .j          (w_ex_j),
        .k          (w_ex_k)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, acceptance and J/K load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_jk   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.pat_valid) begin
                    w_accept    = 1'b1;
                    w_load_jk   = 1'b1;
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                w_state_nxt = CHECK;
            end
            CHECK: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_load_jk   = 1'b1;
                    w_state_nxt = DRIVE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pattern, bit index, error count, mismatch pulse and registered J/K drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= '0;
            r_idx <= '0;
            r_err <= '0;
            r_mis <= 1'b0;
            r_j   <= 1'b0;
            r_k   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pat <= bus.pat_data;
                r_idx <= '0;
                r_err <= '0;
            end else if (r_state == CHECK) begin
                if (!w_last) begin
                    r_idx <= w_idx_nxt;
                end
                if (w_bit_mis && (r_err != CNT_W'(WIDTH))) begin
                    r_err <= r_err + 1'b1;
                end
            end
            r_mis <= (r_state == CHECK) && w_bit_mis;
            // J/K is non-zero only during DRIVE: loaded on entry, cleared on exit
            r_j   <= w_load_jk ? w_ex_j : 1'b0;
            r_k   <= w_load_jk ? w_ex_k : 1'b0;
        end
    end

    assign bus.pat_ready  = (r_state == IDLE);
    assign bus.j_o        = r_j;
    assign bus.k_o        = r_k;
    assign bus.mismatch_o = r_mis;
    assign bus.done_o     = (r_state == DONE);
    assign bus.err_cnt_o  = r_err;
    assign bus.pass_o     = (r_state == DONE) && (r_err == '0);

endmodule
